// File: rtl/dm_arb_pkg.sv
// Shared types and sizing for the MEM/DBG single-port RAM arbiter.
// Optional build macro: DM_DBG_WRITE_EN (debug requester may write).
package dm_arb_pkg;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned WEN_W          = 4;
   localparam int unsigned STARVE_MAX_DEF = 8;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_e;

   typedef enum logic {
      REQ_MEM = 1'b0,
      REQ_DBG = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [WEN_W-1:0]  wen;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } ram_cmd_t;

   // Starvation counter width; at least one bit so a zero limit still elaborates.
   function automatic int unsigned starve_w(input int unsigned starve_max);
      int unsigned w;
      w = $clog2(starve_max + 1);
      return (w == 0) ? 1 : w;
   endfunction

   localparam int unsigned STARVE_W = starve_w(STARVE_MAX_DEF);

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and RAM signal bundle for dm_arbiter.
interface dm_arbiter_if;
   import dm_arb_pkg::*;

   logic                mem_req;
   logic [WEN_W-1:0]    mem_wen;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   logic                dbg_req;
   logic [WEN_W-1:0]    dbg_wen;
   logic [ADDR_W-1:0]   dbg_addr;
   logic [DATA_W-1:0]   dbg_wdata;
   logic [DATA_W-1:0]   dbg_rdata;
   logic                dbg_ack;

   logic                ram_en;
   logic [WEN_W-1:0]    ram_wen;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;
   logic                busy;

   // Arbiter side
   modport slave (
      input  mem_req, mem_wen, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  dbg_req, dbg_wen, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output ram_en, ram_wen, ram_addr, ram_wdata,
      input  ram_rdata,
      output busy
   );

   // Requester/RAM side
   modport master (
      output mem_req, mem_wen, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output dbg_req, dbg_wen, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  ram_en, ram_wen, ram_addr, ram_wdata,
      output ram_rdata,
      input  busy
   );

endinterface

// File: rtl/dm_arb_pick.sv
// Winner selection: MEM by default, DBG once it has watched STARVE_MAX MEM grants.
module dm_arb_pick
   import dm_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    en,
   input  logic    mem_req,
   input  logic    dbg_req,
   output logic    gnt_vld,
   output req_id_e gnt_id
);

   localparam int unsigned      CNT_W   = starve_w(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             dbg_wins;

   always_comb begin
      dbg_wins     = 1'b0;
      gnt_vld      = 1'b0;
      gnt_id       = REQ_MEM;
      starve_cnt_d = starve_cnt_q;

      dbg_wins = dbg_req && ((starve_cnt_q == CNT_MAX) || !mem_req);
      gnt_vld  = en && (mem_req || dbg_req);
      gnt_id   = dbg_wins ? REQ_DBG : REQ_MEM;

      // Count only MEM grants that bypassed a waiting DBG request.
      if (!dbg_req) begin
         starve_cnt_d = '0;
      end else if (gnt_vld && (gnt_id == REQ_DBG)) begin
         starve_cnt_d = '0;
      end else if (gnt_vld && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter onto a synchronous-read RAM; writes take 1 cycle, reads 2.
// Build macro DM_DBG_WRITE_EN lets the debug requester write; otherwise DBG is read-only.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input logic          clk,
   input logic          reset,
   dm_arbiter_if.slave  bus
);

   state_e            state_q, state_d;
   req_id_e           id_q, id_d;
   logic [DATA_W-1:0] mem_hold_q, mem_hold_d;
   logic [DATA_W-1:0] dbg_hold_q, dbg_hold_d;

   logic     gnt_ok;
   logic     gnt_vld;
   req_id_e  gnt_id;
   ram_cmd_t mem_cmd, dbg_cmd, cmd;

   // Grants are suppressed while reset is held so every output reads 0.
   assign gnt_ok = (state_q == ST_IDLE) && !reset;

   dm_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk     (clk),
      .reset   (reset),
      .en      (gnt_ok),
      .mem_req (bus.mem_req),
      .dbg_req (bus.dbg_req),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

`ifdef DM_DBG_WRITE_EN
   assign dbg_cmd = '{wen: bus.dbg_wen, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
`else
   logic unused_dbg_wen;
   assign unused_dbg_wen = ^bus.dbg_wen;
   assign dbg_cmd = '{wen: '0, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
`endif

   assign mem_cmd = '{wen: bus.mem_wen, addr: bus.mem_addr, wdata: bus.mem_wdata};

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      mem_hold_d = mem_hold_q;
      dbg_hold_d = dbg_hold_q;
      cmd        = '0;

      bus.ram_en    = 1'b0;
      bus.ram_wen   = '0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.mem_ack   = 1'b0;
      bus.dbg_ack   = 1'b0;
      bus.mem_rdata = mem_hold_q;
      bus.dbg_rdata = dbg_hold_q;
      bus.busy      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               cmd           = (gnt_id == REQ_DBG) ? dbg_cmd : mem_cmd;
               bus.ram_en    = 1'b1;
               bus.ram_wen   = cmd.wen;
               bus.ram_addr  = cmd.addr;
               bus.ram_wdata = cmd.wdata;
               if (cmd.wen != '0) begin
                  bus.mem_ack = (gnt_id == REQ_MEM);
                  bus.dbg_ack = (gnt_id == REQ_DBG);
               end else begin
                  state_d = ST_RD_WAIT;
                  id_d    = gnt_id;
               end
            end
         end
         ST_RD_WAIT: begin
            // RAM data is valid now: pass it through and keep a copy.
            bus.busy = 1'b1;
            state_d  = ST_IDLE;
            if (id_q == REQ_DBG) begin
               bus.dbg_ack   = 1'b1;
               bus.dbg_rdata = bus.ram_rdata;
               dbg_hold_d    = bus.ram_rdata;
            end else begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = bus.ram_rdata;
               mem_hold_d    = bus.ram_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         id_q       <= REQ_MEM;
         mem_hold_q <= '0;
         dbg_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         mem_hold_q <= mem_hold_d;
         dbg_hold_q <= dbg_hold_d;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter (STARVE_MAX = 8).
module tb_dm_arbiter;

`ifdef DM_DBG_WRITE_EN
   localparam bit DBG_WR = 1'b1;
`else
   localparam bit DBG_WR = 1'b0;
`endif

   logic clk;
   logic reset;
   int   total;
   int   bad;

   dm_arbiter_if bus ();

   dm_arbiter #(
      .STARVE_MAX (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      logic        e_mem, e_dbg, e_en, e_busy;
      logic [3:0]  e_wen;
      logic [31:0] e_addr, e_drd;
      int          drop;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.mem_req   = 1'b1;
      bus.mem_wen   = 4'h0;
      bus.mem_addr  = 32'h10;
      bus.mem_wdata = 32'h0;
      bus.dbg_req   = 1'b1;
      bus.dbg_wen   = 4'h0;
      bus.dbg_addr  = 32'h0;
      bus.dbg_wdata = 32'h0;
      bus.ram_rdata = 32'h5555_AAAA;

      // Outputs are quiet while reset is held, even with requests pending
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk1("rst_ram_en",   bus.ram_en,  1'b0);
      chk1("rst_busy",     bus.busy,    1'b0);
      chk1("rst_mem_ack",  bus.mem_ack, 1'b0);
      chk1("rst_dbg_ack",  bus.dbg_ack, 1'b0);
      chk ("rst_mem_rd",   bus.mem_rdata, 32'h0);
      chk ("rst_dbg_rd",   bus.dbg_rdata, 32'h0);
      chk ("rst_ram_addr", bus.ram_addr,  32'h0);

      // MEM read of 0x10: grant on first edge after reset release
      @(negedge clk);
      reset = 1'b0;
      bus.dbg_req = 1'b0;
      #1;
      chk1("rd_T_en",    bus.ram_en,  1'b1);
      chk ("rd_T_addr",  bus.ram_addr, 32'h10);
      chk ("rd_T_wen",   32'(bus.ram_wen), 32'h0);
      chk1("rd_T_ack",   bus.mem_ack, 1'b0);
      chk1("rd_T_busy",  bus.busy,    1'b0);
      @(negedge clk);
      bus.ram_rdata = 32'hDEAD_BEEF;
      #1;
      chk1("rd_T1_ack",  bus.mem_ack, 1'b1);
      chk ("rd_T1_data", bus.mem_rdata, 32'hDEAD_BEEF);
      chk1("rd_T1_busy", bus.busy,    1'b1);
      chk1("rd_T1_en",   bus.ram_en,  1'b0);
      @(negedge clk);
      bus.mem_req   = 1'b0;
      bus.ram_rdata = 32'h1234_5678;
      #1;
      chk ("rd_hold",    bus.mem_rdata, 32'hDEAD_BEEF);
      chk1("rd_T2_busy", bus.busy,    1'b0);
      chk1("rd_T2_ack",  bus.mem_ack, 1'b0);

      // Back-to-back MEM writes
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_req   = 1'b1;
         bus.mem_wen   = 4'hF;
         bus.mem_addr  = 32'(4 * i);
         bus.mem_wdata = 32'hA000_0000 + 32'(i);
         #1;
         chk1("wr_ack",   bus.mem_ack, 1'b1);
         chk1("wr_en",    bus.ram_en,  1'b1);
         chk ("wr_wen",   32'(bus.ram_wen), 32'hF);
         chk ("wr_addr",  bus.ram_addr,  32'(4 * i));
         chk ("wr_wdata", bus.ram_wdata, 32'hA000_0000 + 32'(i));
         chk1("wr_busy",  bus.busy,    1'b0);
      end
      @(negedge clk);
      bus.mem_req = 1'b0;
      #1;
      chk1("drop_en",  bus.ram_en,  1'b0);
      chk1("drop_ack", bus.mem_ack, 1'b0);

      // Both requesters issue writes continuously; DBG must break in after 8 MEM grants
      drop = DBG_WR ? 9 : 10;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.mem_req   = 1'b1;
            bus.mem_wen   = 4'hF;
            bus.mem_addr  = 32'h40;
            bus.mem_wdata = 32'h1111_0000;
            bus.dbg_req   = 1'b1;
            bus.dbg_wen   = 4'hF;
            bus.dbg_addr  = 32'h200;
            bus.dbg_wdata = 32'h2222_0000;
            bus.ram_rdata = 32'hCAFE_F00D;
         end
         if (c == drop) bus.dbg_req = 1'b0;
         #1;
         e_mem = 1'b1; e_dbg = 1'b0; e_en = 1'b1; e_busy = 1'b0;
         e_wen = 4'hF; e_addr = 32'h40;
         e_drd = (!DBG_WR && c >= 9) ? 32'hCAFE_F00D : 32'h0;
         if (c == 8) begin
            e_mem  = 1'b0;
            e_dbg  = DBG_WR;
            e_wen  = DBG_WR ? 4'hF : 4'h0;
            e_addr = 32'h200;
         end else if (c == 9 && !DBG_WR) begin
            e_mem  = 1'b0;
            e_dbg  = 1'b1;
            e_en   = 1'b0;
            e_busy = 1'b1;
            e_wen  = 4'h0;
            e_addr = 32'h0;
         end
         chk1("stv_mem_ack", bus.mem_ack, e_mem);
         chk1("stv_dbg_ack", bus.dbg_ack, e_dbg);
         chk1("stv_dual",    bus.mem_ack & bus.dbg_ack, 1'b0);
         chk1("stv_en",      bus.ram_en,  e_en);
         chk1("stv_busy",    bus.busy,    e_busy);
         chk ("stv_wen",     32'(bus.ram_wen), 32'(e_wen));
         chk ("stv_addr",    bus.ram_addr,  e_addr);
         chk ("stv_dbg_rd",  bus.dbg_rdata, e_drd);
      end

      // Reset in RD_WAIT aborts the read and clears the hold registers
      @(negedge clk);
      bus.dbg_req  = 1'b0;
      bus.mem_wen  = 4'h0;
      bus.mem_addr = 32'h20;
      #1;
      chk1("ab_T_en",   bus.ram_en, 1'b1);
      chk ("ab_T_addr", bus.ram_addr, 32'h20);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk1("ab_ack",    bus.mem_ack, 1'b0);
      chk1("ab_busy",   bus.busy,    1'b0);
      chk1("ab_en",     bus.ram_en,  1'b0);
      chk ("ab_mem_rd", bus.mem_rdata, 32'h0);
      chk ("ab_dbg_rd", bus.dbg_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_req = 1'b0;
      #1;
      chk1("ab_post_ack",  bus.mem_ack, 1'b0);
      chk1("ab_post_busy", bus.busy,    1'b0);
      chk ("ab_post_rd",   bus.mem_rdata, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: consecutive MEM grants a pending DBG request tolerates before it is forced.
REQ-002 SHALL have the following ports, in this order:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have the MEM requester ports:
- mem_req  in  1  MEM-stage access request.
- mem_wen  in  4  byte write enables; 0 = read.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_rdata  out  32  read data.
- mem_ack  out  1  access-complete pulse.
REQ-004 SHALL have the debug requester ports:
- dbg_req  in  1  debug/display request.
- dbg_wen  in  4  byte write enables.
- dbg_addr  in  32  byte address.
- dbg_wdata  in  32  write data.
- dbg_rdata  out  32  read data.
- dbg_ack  out  1  access-complete pulse.
REQ-005 SHALL have the RAM ports:
- ram_en  out  1  RAM access strobe.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  synchronous-read data, valid one cycle after ram_en.
- busy  out  1  high while a read is outstanding.

Function
REQ-006 SHALL implement a two-state FSM: IDLE and RD_WAIT.
REQ-007 SHALL grant in IDLE only, and only when at least one req is high.
- Default priority is MEM.
- DBG wins when starve_cnt == STARVE_MAX.
REQ-008 In the grant cycle, SHALL combinationally drive ram_en=1 and ram_addr/ram_wdata/ram_wen from the winner; all RAM outputs SHALL be 0 when no grant is made.
REQ-009 Write grant (wen != 0): the winner's ack SHALL pulse in the same cycle, and the FSM SHALL stay in IDLE, giving 1 write per cycle.
REQ-010 Read grant (wen == 0): the FSM SHALL go to RD_WAIT and latch the winner's identity.
REQ-011 In RD_WAIT, the latched requester's ack SHALL be 1 and its rdata SHALL equal ram_rdata (pass-through).
- ram_rdata SHALL also be captured into that requester's hold register.
- The FSM SHALL return to IDLE; no grant is made in RD_WAIT.
- Read throughput is 1 per 2 cycles.
REQ-012 Outside its ack cycle, each rdata output SHALL present its hold register.
REQ-013 busy SHALL be 1 exactly in RD_WAIT.
REQ-014 Requesters SHALL hold req/addr/wen/wdata stable until ack; the block does not register request fields.
REQ-015 starve_cnt rules:
- Increments on each MEM grant while dbg_req=1, saturating at STARVE_MAX.
- Clears on any DBG grant or whenever dbg_req=0.
REQ-016 mem_ack and dbg_ack SHALL never be 1 in the same cycle.
REQ-017 A req dropped before its ack SHALL be ignored in IDLE; an outstanding read SHALL still complete its ack.
REQ-018 Addresses SHALL pass unmodified; alignment is the requester's responsibility.

Reset
REQ-019 reset SHALL asynchronously force: FSM IDLE, starve_cnt 0, both hold registers 0, latched identity MEM.
REQ-020 During reset, all outputs SHALL be 0.
REQ-021 Reset during RD_WAIT SHALL abort the read with no ack.
REQ-022 The first grant SHALL be possible on the first clock edge after reset deasserts.

Configuration
REQ-023 Macro DM_DBG_WRITE_EN:
- Defined: dbg_wen is honoured per REQ-009.
- Undefined: dbg_wen is ignored, every DBG access is a read, and ram_wen is 0 on DBG grants.

Structure
REQ-024 Package dm_arb_pkg SHALL hold the FSM state enum, the requester-ID encoding (MEM=0, DBG=1) and the starve_cnt width, $clog2(STARVE_MAX+1).
REQ-025 Sub-module dm_arb_pick SHALL contain the priority/starvation selection logic and starve_cnt; the FSM and datapath SHALL be in dm_arbiter.

Verification
REQ-026 MEM read, addr 0x10, RAM word 0xDEADBEEF:
- ram_en in cycle T.
- mem_ack and mem_rdata=0xDEADBEEF in T+1.
- busy=1 in T+1.
REQ-027 mem_req and dbg_req both writes, held high continuously, STARVE_MAX=8: 8 mem_acks, then 1 dbg_ack, then MEM resumes; no same-cycle double ack.
REQ-028 Without DM_DBG_WRITE_EN, a dbg write with wen=4'b1111 gives ram_wen=0; dbg_ack arrives after 2 cycles and returns read data.
REQ-029 reset asserted in RD_WAIT: no ack, busy=0 immediately, hold registers read 0.
REQ-030 Back-to-back MEM writes to 0x0,0x4,0x8: one mem_ack per cycle for 3 cycles; ram_wen=4'b1111 each cycle.
